divisor_restoring: RTL

//  Sequential unsigned restoring divider (shift-subtract). It is the inverse
//  of the lab shift-add multiplier: it computes Q = DV / DR and R = DV % DR,
//  one quotient bit per iteration. It sits beside the multiplier in the

---
 rtl/divisor_restoring_pkg.sv | 5 +
 rtl/divisor_restoring_if.sv | 9 +
 rtl/divisor_restoring_resta_comparador.sv | 11 +
 rtl/divisor_restoring.sv | 79 +++++++
 4 files changed

// File: rtl/divisor_restoring_pkg.sv
// divisor_restoring_pkg: shared FSM encoding and default operand width for the restoring divider
package divisor_restoring_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, SUB = 2'd2, END1 = 2'd3} state_t;
    localparam int N_DEF = 8;
endpackage

// File: rtl/divisor_restoring_if.sv
// divisor_restoring_if: init/done handshake plus operands and results of the divider
import divisor_restoring_pkg::*;
interface divisor_restoring_if #(parameter int N = N_DEF);
    logic init;
    logic [N-1:0] DV, DR, Q, R;
    logic busy, done, div0;
    modport master (output init, DV, DR, input busy, done, div0, Q, R);
    modport slave (input init, DV, DR, output busy, done, div0, Q, R);
endinterface

// File: rtl/divisor_restoring_resta_comparador.sv
// resta_comparador: combinational compare/subtract of the partial remainder against the divisor
import divisor_restoring_pkg::*;
module resta_comparador #(parameter int W = N_DEF + 1) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_ge,
    output logic [W-1:0] o_diff
);
    assign o_ge = i_a >= i_b;
    assign o_diff = i_a - i_b;
endmodule

// File: rtl/divisor_restoring.sv
// divisor_restoring: sequential unsigned restoring divider, one quotient bit per SHIFT/SUB pair
module divisor_restoring
    import divisor_restoring_pkg::*;
#(parameter int N = N_DEF) (
    input logic clk,
    input logic rst,
    divisor_restoring_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    state_t r_state, w_next;
    logic [N:0] r_a, w_diff;
    logic [N-1:0] r_qr, r_d, r_q, r_r;
    logic [CW-1:0] r_cnt;
    logic r_busy, r_done, r_div0, w_ge;
    resta_comparador #(.W(N + 1)) u_rc (.i_a(r_a), .i_b({1'b0, r_d}), .o_ge(w_ge), .o_diff(w_diff));
    always_comb begin
        w_next = r_state == IDLE  ? (bus.init ? (bus.DR == '0 ? END1 : SHIFT) : IDLE) :
                 r_state == SHIFT ? SUB :
                 r_state == SUB   ? (r_cnt == '0 ? END1 : SHIFT) : IDLE;
    end
    always_ff @(posedge clk)
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_qr <= '0;
            r_d <= '0;
            r_cnt <= '0;
            r_q <= '0;
            r_r <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_div0 <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.init) begin
                    r_busy <= 1'b1;
                    if (bus.DR == '0) begin
                        r_q <= '1;
                        r_r <= bus.DV;
                        r_div0 <= 1'b1;
                        r_done <= 1'b1;
                    end else begin
                        r_a <= '0;
                        r_qr <= bus.DV;
                        r_d <= bus.DR;
                        r_cnt <= CW'(N);
                        r_div0 <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_a <= {r_a[N-1:0], r_qr[N-1]};
                    r_qr <= {r_qr[N-2:0], 1'b0};
                    r_cnt <= r_cnt - CW'(1);
                end
                SUB: begin
                    // A restore is simply not writing A back
                    if (w_ge) r_a <= w_diff;
                    r_qr[0] <= w_ge;
                    if (r_cnt == '0) begin
                        r_q <= {r_qr[N-1:1], w_ge};
                        r_r <= w_ge ? w_diff[N-1:0] : r_a[N-1:0];
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end
    assign bus.Q = r_q;
    assign bus.R = r_r;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.div0 = r_div0;
endmodule
